lsu_ctrl: RTL and testbench

- Responder end of the AGU command interface issued by the execution unit.
- Accepts load/store commands, issues word-aligned accesses to the DTCM SRAM port, and tracks outstanding accesses in an in-order FIFO.
- Load results are aligned and extended, then returned on the LSU write-back interface tagged with the command's itag.
- Store completions are returned on the AGU response channel.

---
 rtl/lsu_ctrl_pkg.sv | 21 ++
 rtl/lsu_ctrl_outs_fifo.sv | 56 +++++
 rtl/lsu_ctrl.sv | 123 ++++++++++++
 tb/tb_lsu_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings and outstanding-FIFO entry layout for the load/store unit.
package lsu_ctrl_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int OUTS_DEPTH_DEF = 2;

  // Entry fields, MSB first: {read, itag, size, usign, addr[1:0], err}
  localparam int ENT_READ_W  = 1;
  localparam int ENT_SIZE_W  = 2;
  localparam int ENT_USIGN_W = 1;
  localparam int ENT_OFS_W   = 2;
  localparam int ENT_ERR_W   = 1;

  function automatic int ent_width(input int itag_w);
    return ENT_READ_W + itag_w + ENT_SIZE_W + ENT_USIGN_W + ENT_OFS_W + ENT_ERR_W;
  endfunction

endpackage

// File: rtl/lsu_ctrl_outs_fifo.sv
// Generic synchronous FIFO with count-based full/empty; head is read combinationally.
module lsu_outs_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_do_push;
  logic              w_do_pop;

  assign full      = (r_cnt == CNT_W'(DEPTH));
  assign empty     = (r_cnt == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign rdata     = r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push)
        r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_do_pop)
        r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push)
      r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: AGU commands to DTCM, in-order response steering and load extension.
// Optional misaligned-access trapping is enabled by defining LSU_MISALIGN_CHK_EN.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 16,
  parameter int ITAG_W     = 1,
  parameter int OUTS_DEPTH = OUTS_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                agu_cmd_valid,
  output logic                agu_cmd_ready,
  input  logic [ADDR_W-1:0]   agu_cmd_addr,
  input  logic                agu_cmd_read,
  input  logic [ITAG_W-1:0]   agu_cmd_itag,
  input  logic [1:0]          agu_cmd_size,
  input  logic                agu_cmd_usign,
  input  logic [XLEN-1:0]     agu_cmd_wdata,
  input  logic [XLEN/8-1:0]   agu_cmd_wmask,
  output logic                agu_rsp_valid,
  input  logic                agu_rsp_ready,
  output logic                agu_rsp_err,
  output logic                lsu_wbck_o_valid,
  input  logic                lsu_wbck_o_ready,
  output logic [XLEN-1:0]     lsu_wbck_o_data,
  output logic [ITAG_W-1:0]   lsu_wbck_o_itag,
  output logic                lsu_wbck_o_err,
  output logic                dtcm_cmd_valid,
  input  logic                dtcm_cmd_ready,
  output logic [ADDR_W-1:0]   dtcm_cmd_addr,
  output logic                dtcm_cmd_read,
  output logic [XLEN-1:0]     dtcm_cmd_wdata,
  output logic [XLEN/8-1:0]   dtcm_cmd_wmask,
  input  logic                dtcm_rsp_valid,
  output logic                dtcm_rsp_ready,
  input  logic [XLEN-1:0]     dtcm_rsp_rdata,
  output logic                lsu_idle
);

  localparam int ENT_W = ent_width(ITAG_W);

  logic              w_full, w_empty, w_push, w_pop, w_misalign, w_local;
  logic [ENT_W-1:0]  w_push_ent, w_head;
  logic              w_h_read, w_h_usign, w_h_err;
  logic [ITAG_W-1:0] w_h_itag;
  logic [1:0]        w_h_size, w_h_ofs;
  logic [XLEN-1:0]   w_shifted, w_ext;

`ifdef LSU_MISALIGN_CHK_EN
  always_comb begin
    case (agu_cmd_size)
      SIZE_B:  w_misalign = 1'b0;
      SIZE_H:  w_misalign = agu_cmd_addr[0];
      default: w_misalign = |agu_cmd_addr[1:0];
    endcase
  end
  // Trapped entries complete from the FIFO alone, never waiting on the DTCM.
  assign w_local        = ~w_empty & w_h_err;
  assign agu_rsp_err    = w_local;
  assign lsu_wbck_o_err = w_local;
`else
  assign w_misalign     = 1'b0;
  assign w_local        = 1'b0;
  assign agu_rsp_err    = 1'b0;
  assign lsu_wbck_o_err = 1'b0;
  logic w_unused_err;
  assign w_unused_err   = w_h_err;
`endif

  // A misaligned command needs no DTCM slot, so only FIFO space gates it.
  assign agu_cmd_ready  = ~w_full & (w_misalign | dtcm_cmd_ready);
  assign dtcm_cmd_valid = agu_cmd_valid & ~w_full & ~w_misalign;
  assign dtcm_cmd_addr  = {agu_cmd_addr[ADDR_W-1:2], 2'b00};
  assign dtcm_cmd_read  = agu_cmd_read;
  assign dtcm_cmd_wdata = agu_cmd_wdata;
  assign dtcm_cmd_wmask = agu_cmd_wmask;
  assign w_push         = agu_cmd_valid & agu_cmd_ready;
  assign w_push_ent     = {agu_cmd_read, agu_cmd_itag, agu_cmd_size, agu_cmd_usign,
                           agu_cmd_addr[1:0], w_misalign};

  lsu_outs_fifo #(.DATA_W(ENT_W), .DEPTH(OUTS_DEPTH)) u_outs_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata (w_push_ent),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign {w_h_read, w_h_itag, w_h_size, w_h_usign, w_h_ofs, w_h_err} = w_head;

  assign lsu_wbck_o_valid = ~w_empty & w_h_read & (w_local | dtcm_rsp_valid);
  assign agu_rsp_valid    = ~w_empty & ~w_h_read & (w_local | dtcm_rsp_valid);
  assign dtcm_rsp_ready   = ~w_empty & ~w_local & (w_h_read ? lsu_wbck_o_ready : agu_rsp_ready);
  assign w_pop            = w_local ? ((lsu_wbck_o_valid & lsu_wbck_o_ready) |
                                       (agu_rsp_valid & agu_rsp_ready))
                                    : (dtcm_rsp_valid & dtcm_rsp_ready);

  assign w_shifted = dtcm_rsp_rdata >> {w_h_ofs, 3'b000};

  always_comb begin
    case (w_h_size)
      SIZE_B:  w_ext = {{(XLEN-8){~w_h_usign & w_shifted[7]}}, w_shifted[7:0]};
      SIZE_H:  w_ext = {{(XLEN-16){~w_h_usign & w_shifted[15]}}, w_shifted[15:0]};
      default: w_ext = w_shifted;
    endcase
  end

  assign lsu_wbck_o_data = w_local ? '0 : w_ext;
  assign lsu_wbck_o_itag = w_h_itag;
  assign lsu_idle        = w_empty;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) assert (!(dtcm_rsp_valid && w_empty));
  end
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl (default depth 2, XLEN 32).
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        agu_cmd_valid, agu_cmd_ready, agu_cmd_read, agu_cmd_usign;
  logic [15:0] agu_cmd_addr;
  logic [0:0]  agu_cmd_itag;
  logic [1:0]  agu_cmd_size;
  logic [31:0] agu_cmd_wdata;
  logic [3:0]  agu_cmd_wmask;
  logic        agu_rsp_valid, agu_rsp_ready, agu_rsp_err;
  logic        lsu_wbck_o_valid, lsu_wbck_o_ready, lsu_wbck_o_err;
  logic [31:0] lsu_wbck_o_data;
  logic [0:0]  lsu_wbck_o_itag;
  logic        dtcm_cmd_valid, dtcm_cmd_ready, dtcm_cmd_read;
  logic [15:0] dtcm_cmd_addr;
  logic [31:0] dtcm_cmd_wdata;
  logic [3:0]  dtcm_cmd_wmask;
  logic        dtcm_rsp_valid, dtcm_rsp_ready;
  logic [31:0] dtcm_rsp_rdata;
  logic        lsu_idle;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .rst(rst),
    .agu_cmd_valid(agu_cmd_valid), .agu_cmd_ready(agu_cmd_ready),
    .agu_cmd_addr(agu_cmd_addr), .agu_cmd_read(agu_cmd_read),
    .agu_cmd_itag(agu_cmd_itag), .agu_cmd_size(agu_cmd_size),
    .agu_cmd_usign(agu_cmd_usign), .agu_cmd_wdata(agu_cmd_wdata),
    .agu_cmd_wmask(agu_cmd_wmask),
    .agu_rsp_valid(agu_rsp_valid), .agu_rsp_ready(agu_rsp_ready),
    .agu_rsp_err(agu_rsp_err),
    .lsu_wbck_o_valid(lsu_wbck_o_valid), .lsu_wbck_o_ready(lsu_wbck_o_ready),
    .lsu_wbck_o_data(lsu_wbck_o_data), .lsu_wbck_o_itag(lsu_wbck_o_itag),
    .lsu_wbck_o_err(lsu_wbck_o_err),
    .dtcm_cmd_valid(dtcm_cmd_valid), .dtcm_cmd_ready(dtcm_cmd_ready),
    .dtcm_cmd_addr(dtcm_cmd_addr), .dtcm_cmd_read(dtcm_cmd_read),
    .dtcm_cmd_wdata(dtcm_cmd_wdata), .dtcm_cmd_wmask(dtcm_cmd_wmask),
    .dtcm_rsp_valid(dtcm_rsp_valid), .dtcm_rsp_ready(dtcm_rsp_ready),
    .dtcm_rsp_rdata(dtcm_rsp_rdata),
    .lsu_idle(lsu_idle)
  );

  task automatic drive_idle();
    agu_cmd_valid = 0; agu_cmd_addr = '0; agu_cmd_read = 0; agu_cmd_itag = '0;
    agu_cmd_size = 2'd2; agu_cmd_usign = 0; agu_cmd_wdata = '0; agu_cmd_wmask = '0;
    agu_rsp_ready = 1; lsu_wbck_o_ready = 1; dtcm_cmd_ready = 1;
    dtcm_rsp_valid = 0; dtcm_rsp_rdata = '0;
  endtask

  task automatic drive_cmd(input logic [15:0] addr, input logic rd, input logic [0:0] itag,
                           input logic [1:0] size, input logic usign);
    agu_cmd_valid = 1; agu_cmd_addr = addr; agu_cmd_read = rd; agu_cmd_itag = itag;
    agu_cmd_size = size; agu_cmd_usign = usign;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({lsu_wbck_o_valid, agu_rsp_valid, dtcm_cmd_valid, dtcm_rsp_ready} !== 4'b0) begin
      n_err++; $display("FAIL reset_valids got=%b exp=0000",
        {lsu_wbck_o_valid, agu_rsp_valid, dtcm_cmd_valid, dtcm_rsp_ready}); end
    n_cmp++; if (lsu_idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got=%b exp=1", lsu_idle); end
    rst = 0;
    @(negedge clk);
    $display("reset: done");
  endtask

  // Issue one load, answer it on the next cycle and check the written-back value.
  task automatic do_load(input string name, input logic [15:0] addr, input logic [0:0] itag,
                         input logic [1:0] size, input logic usign, input logic [31:0] rdata,
                         input logic [15:0] exp_addr, input logic [31:0] exp_data);
    @(negedge clk);
    drive_cmd(addr, 1'b1, itag, size, usign);
    #1;
    n_cmp++; if ({dtcm_cmd_valid, dtcm_cmd_read, agu_cmd_ready} !== 3'b111) begin
      n_err++; $display("FAIL %s_cmd got=%b exp=111", name, {dtcm_cmd_valid, dtcm_cmd_read, agu_cmd_ready}); end
    n_cmp++; if (dtcm_cmd_addr !== exp_addr) begin
      n_err++; $display("FAIL %s_addr got=%h exp=%h", name, dtcm_cmd_addr, exp_addr); end
    @(negedge clk);
    agu_cmd_valid = 0; dtcm_rsp_valid = 1; dtcm_rsp_rdata = rdata;
    #1;
    n_cmp++; if ({lsu_wbck_o_valid, agu_rsp_valid, dtcm_rsp_ready, lsu_wbck_o_err} !== 4'b1010) begin
      n_err++; $display("FAIL %s_rsp got=%b exp=1010", name,
        {lsu_wbck_o_valid, agu_rsp_valid, dtcm_rsp_ready, lsu_wbck_o_err}); end
    n_cmp++; if (lsu_wbck_o_data !== exp_data || lsu_wbck_o_itag !== itag) begin
      n_err++; $display("FAIL %s_data got=%h/%b exp=%h/%b", name, lsu_wbck_o_data, lsu_wbck_o_itag, exp_data, itag); end
    @(negedge clk);
    dtcm_rsp_valid = 0;
    #1;
    n_cmp++; if (lsu_idle !== 1'b1) begin n_err++; $display("FAIL %s_idle got=%b exp=1", name, lsu_idle); end
    $display("load %s: addr=%h data=%h", name, addr, lsu_wbck_o_data);
  endtask

  task automatic test_loads();
    do_load("word",  16'h0010, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 16'h0010, 32'hDEADBEEF);
    do_load("sbyte", 16'h0013, 1'b0, 2'd0, 1'b0, 32'h80FF0000, 16'h0010, 32'hFFFFFF80);
    do_load("ubyte", 16'h0013, 1'b1, 2'd0, 1'b1, 32'h80FF0000, 16'h0010, 32'h00000080);
    do_load("shalf", 16'h0002, 1'b0, 2'd1, 1'b0, 32'h80FF0000, 16'h0000, 32'hFFFF80FF);
    do_load("uhalf", 16'h0002, 1'b1, 2'd1, 1'b1, 32'h80FF0000, 16'h0000, 32'h000080FF);
    do_load("size3", 16'h0044, 1'b0, 2'd3, 1'b0, 32'hCAFEF00D, 16'h0044, 32'hCAFEF00D);
  endtask

  task automatic test_store();
    @(negedge clk);
    drive_cmd(16'h0020, 1'b0, 1'b0, 2'd2, 1'b0);
    agu_cmd_wdata = 32'h12345678; agu_cmd_wmask = 4'hF;
    #1;
    n_cmp++; if ({dtcm_cmd_valid, dtcm_cmd_read} !== 2'b10 || dtcm_cmd_addr !== 16'h0020) begin
      n_err++; $display("FAIL store_cmd got=%b addr=%h exp=10 addr=0020", {dtcm_cmd_valid, dtcm_cmd_read}, dtcm_cmd_addr); end
    n_cmp++; if (dtcm_cmd_wdata !== 32'h12345678 || dtcm_cmd_wmask !== 4'hF) begin
      n_err++; $display("FAIL store_wdata got=%h/%h exp=12345678/f", dtcm_cmd_wdata, dtcm_cmd_wmask); end
    @(negedge clk);
    agu_cmd_valid = 0; dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'h0;
    #1;
    n_cmp++; if ({agu_rsp_valid, lsu_wbck_o_valid, dtcm_rsp_ready, agu_rsp_err} !== 4'b1010) begin
      n_err++; $display("FAIL store_rsp got=%b exp=1010",
        {agu_rsp_valid, lsu_wbck_o_valid, dtcm_rsp_ready, agu_rsp_err}); end
    @(negedge clk);
    dtcm_rsp_valid = 0;
    #1;
    n_cmp++; if ({agu_rsp_valid, lsu_idle} !== 2'b01) begin
      n_err++; $display("FAIL store_done got=%b exp=01", {agu_rsp_valid, lsu_idle}); end
    $display("store: addr=0020 wdata=12345678");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_cmd(16'h0004, 1'b1, 1'b0, 2'd2, 1'b0);
    @(negedge clk);
    drive_cmd(16'h0008, 1'b1, 1'b1, 2'd2, 1'b0);
    @(negedge clk);
    drive_cmd(16'h000C, 1'b1, 1'b0, 2'd2, 1'b0);
    #1;
    n_cmp++; if ({agu_cmd_ready, dtcm_cmd_valid, lsu_idle} !== 3'b000) begin
      n_err++; $display("FAIL full_block got=%b exp=000", {agu_cmd_ready, dtcm_cmd_valid, lsu_idle}); end
    agu_cmd_valid = 0; dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'h11111111; lsu_wbck_o_ready = 0;
    #1;
    n_cmp++; if ({lsu_wbck_o_valid, dtcm_rsp_ready} !== 2'b10 || lsu_wbck_o_itag !== 1'b0) begin
      n_err++; $display("FAIL stall got=%b itag=%b exp=10 itag=0", {lsu_wbck_o_valid, dtcm_rsp_ready}, lsu_wbck_o_itag); end
    @(negedge clk);
    // Still full after a stalled cycle; pop and a new command in the same cycle must not bypass.
    agu_cmd_valid = 1; lsu_wbck_o_ready = 1;
    #1;
    n_cmp++; if ({dtcm_rsp_ready, agu_cmd_ready, lsu_wbck_o_itag, lsu_wbck_o_data} !== {2'b10, 1'b0, 32'h11111111}) begin
      n_err++; $display("FAIL no_bypass got=%b%b itag=%b data=%h exp=10 itag=0 data=11111111",
        dtcm_rsp_ready, agu_cmd_ready, lsu_wbck_o_itag, lsu_wbck_o_data); end
    @(negedge clk);
    agu_cmd_valid = 0; dtcm_rsp_rdata = 32'h22222222;
    #1;
    n_cmp++; if ({lsu_wbck_o_valid, lsu_wbck_o_itag, lsu_wbck_o_data} !== {2'b11, 32'h22222222}) begin
      n_err++; $display("FAIL second_rsp got=%b%b data=%h exp=11 data=22222222",
        lsu_wbck_o_valid, lsu_wbck_o_itag, lsu_wbck_o_data); end
    @(negedge clk);
    dtcm_rsp_valid = 0;
    #1;
    n_cmp++; if ({lsu_idle, agu_cmd_ready} !== 2'b11) begin
      n_err++; $display("FAIL drain got=%b exp=11", {lsu_idle, agu_cmd_ready}); end
    $display("back_to_back: two loads in order");
  endtask

  task automatic test_misalign();
    @(negedge clk);
    drive_cmd(16'h0022, 1'b1, 1'b1, 2'd2, 1'b0);
    #1;
`ifdef LSU_MISALIGN_CHK_EN
    n_cmp++; if ({dtcm_cmd_valid, agu_cmd_ready} !== 2'b01) begin
      n_err++; $display("FAIL mis_cmd got=%b exp=01", {dtcm_cmd_valid, agu_cmd_ready}); end
    @(negedge clk);
    agu_cmd_valid = 0;
    #1;
    n_cmp++; if ({lsu_wbck_o_valid, lsu_wbck_o_err, dtcm_rsp_ready, lsu_wbck_o_data} !== {3'b110, 32'h0}) begin
      n_err++; $display("FAIL mis_rsp got=%b%b%b data=%h exp=110 data=0",
        lsu_wbck_o_valid, lsu_wbck_o_err, dtcm_rsp_ready, lsu_wbck_o_data); end
`else
    n_cmp++; if ({dtcm_cmd_valid, agu_cmd_ready} !== 2'b11 || dtcm_cmd_addr !== 16'h0020) begin
      n_err++; $display("FAIL mis_cmd got=%b addr=%h exp=11 addr=0020", {dtcm_cmd_valid, agu_cmd_ready}, dtcm_cmd_addr); end
    @(negedge clk);
    agu_cmd_valid = 0; dtcm_rsp_valid = 1; dtcm_rsp_rdata = 32'h11223344;
    #1;
    n_cmp++; if ({lsu_wbck_o_valid, lsu_wbck_o_err, lsu_wbck_o_data} !== {2'b10, 32'h00001122}) begin
      n_err++; $display("FAIL mis_rsp got=%b%b data=%h exp=10 data=00001122",
        lsu_wbck_o_valid, lsu_wbck_o_err, lsu_wbck_o_data); end
`endif
    @(negedge clk);
    dtcm_rsp_valid = 0;
    #1;
    n_cmp++; if (lsu_idle !== 1'b1) begin n_err++; $display("FAIL mis_idle got=%b exp=1", lsu_idle); end
    $display("misalign: word load at 0022");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_cmd(16'h0030, 1'b1, 1'b0, 2'd2, 1'b0);
    @(negedge clk);
    drive_cmd(16'h0034, 1'b0, 1'b1, 2'd2, 1'b0);
    @(negedge clk);
    agu_cmd_valid = 0;
    #1;
    n_cmp++; if (lsu_idle !== 1'b0) begin n_err++; $display("FAIL pre_rst_idle got=%b exp=0", lsu_idle); end
    #2 rst = 1;
    #1;
    n_cmp++; if ({lsu_idle, lsu_wbck_o_valid, agu_rsp_valid, dtcm_rsp_ready, agu_cmd_ready} !== 5'b10001) begin
      n_err++; $display("FAIL async_rst got=%b exp=10001",
        {lsu_idle, lsu_wbck_o_valid, agu_rsp_valid, dtcm_rsp_ready, agu_cmd_ready}); end
    @(negedge clk);
    rst = 0;
    $display("reset_mid: flushed two entries");
    do_load("post_rst", 16'h0050, 1'b1, 2'd0, 1'b1, 32'h000000A5, 16'h0050, 32'h000000A5);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store();
    test_back_to_back();
    test_misalign();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
